// File: rtl/y_out_drain.sv
// y_out_drain: captures whole y vectors from the y-accumulation stage into a
// small vector FIFO and streams them out one element per beat over a
// valid/ready interface. The upstream side has no backpressure, so a vector
// that finds the FIFO full is dropped and a sticky overflow flag is raised.
module y_out_drain #(
    parameter int DW     = 16,
    parameter int H_TILE = 1,
    parameter int P_TILE = 1,
    parameter int DEPTH  = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        valid_i,
    input  logic [H_TILE*P_TILE*DW-1:0]                 y_i,
    output logic                                        m_valid_o,
    input  logic                                        m_ready_i,
    output logic [DW-1:0]                               m_data_o,
    output logic [((H_TILE > 1) ? $clog2(H_TILE) : 1)-1:0] m_h_o,
    output logic [((P_TILE > 1) ? $clog2(P_TILE) : 1)-1:0] m_p_o,
    output logic                                        m_last_o,
    output logic [$clog2(DEPTH):0]                      level_o,
    output logic                                        overflow_o
);

    localparam int N   = H_TILE * P_TILE;
    localparam int HW  = (H_TILE > 1) ? $clog2(H_TILE) : 1;
    localparam int PW  = (P_TILE > 1) ? $clog2(P_TILE) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int LNW = (N > 1) ? $clog2(N) : 1;

    // Vector storage and its bookkeeping.
    logic [N*DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [HW-1:0]   r_h_cnt;
    logic [PW-1:0]   r_p_cnt;
    logic            r_overflow;

    logic            w_h_last;
    logic            w_p_last;
    logic            w_beat;
    logic            w_pop;
    logic            w_accept;
    logic [LNW-1:0]  w_lane;
    logic [N*DW-1:0] w_head;
    logic [DW-1:0]   w_elem;

    assign m_valid_o = (r_level != '0);
    assign w_h_last  = (r_h_cnt == HW'(H_TILE - 1));
    assign w_p_last  = (r_p_cnt == PW'(P_TILE - 1));
    assign w_beat    = m_valid_o & m_ready_i;
    // The head vector leaves the FIFO on the beat carrying its final lane.
    assign w_pop     = w_beat & w_h_last & w_p_last;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_accept  = valid_i & ((r_level < LW'(DEPTH)) | w_pop);

    // Lane index of the current element; multiply by a constant, no divider.
    assign w_lane    = LNW'(r_h_cnt) * LNW'(P_TILE) + LNW'(r_p_cnt);
    assign w_head    = r_mem[r_rd_ptr];

    // Select the current lane out of the head vector.
    always_comb begin
        // NOTE: default assignment first so the mux never infers a latch.
        w_elem = '0;
        for (int i = 0; i < N; i++) begin
            if (w_lane == LNW'(i)) begin
                w_elem = w_head[i*DW +: DW];
            end
        end
    end

    // Data reads as zero when nothing is presented (stale FIFO contents hidden).
    assign m_data_o   = m_valid_o ? w_elem : '0;
    assign m_h_o      = r_h_cnt;
    assign m_p_o      = r_p_cnt;
    assign m_last_o   = w_h_last & w_p_last & m_valid_o;
    assign level_o    = r_level;
    assign overflow_o = r_overflow;

    // Vector storage write on accept.
    // NOTE: the storage array carries no reset; pointers and level define
    // which entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= y_i;
        end
    end

    // Pointers, occupancy, lane counters and the sticky overflow flag.
    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_h_cnt    <= '0;
            r_p_cnt    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            if (w_beat) begin
                if (w_p_last) begin
                    r_p_cnt <= '0;
                    r_h_cnt <= w_h_last ? '0 : r_h_cnt + HW'(1);
                end else begin
                    r_p_cnt <= r_p_cnt + PW'(1);
                end
            end

            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (valid_i && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_y_out_drain.sv
// Bench for y_out_drain: two instances (2x2 lanes and 1x1 lane), driven by
// a stimulus process that keeps a queue-of-elements model and a monitor that
// compares every beat and every cycle's status against that model.
module tb_y_out_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: H_TILE=2, P_TILE=2, DEPTH=4
    logic        rst_a, valid_a, ready_a, mv_a, last_a, ovf_a;
    logic [63:0] y_a;
    logic [15:0] data_a;
    logic [0:0]  h_a, p_a;
    logic [2:0]  level_a;

    // Instance B: H_TILE=1, P_TILE=1, DEPTH=4
    logic        rst_b, valid_b, ready_b, mv_b, last_b, ovf_b;
    logic [15:0] y_b;
    logic [15:0] data_b;
    logic [0:0]  h_b, p_b;
    logic [2:0]  level_b;

    y_out_drain #(.DW(16), .H_TILE(2), .P_TILE(2), .DEPTH(4)) u_a (
        .clk(clk), .rst(rst_a), .valid_i(valid_a), .y_i(y_a),
        .m_valid_o(mv_a), .m_ready_i(ready_a), .m_data_o(data_a),
        .m_h_o(h_a), .m_p_o(p_a), .m_last_o(last_a),
        .level_o(level_a), .overflow_o(ovf_a)
    );

    y_out_drain #(.DW(16), .H_TILE(1), .P_TILE(1), .DEPTH(4)) u_b (
        .clk(clk), .rst(rst_b), .valid_i(valid_b), .y_i(y_b),
        .m_valid_o(mv_b), .m_ready_i(ready_b), .m_data_o(data_b),
        .m_h_o(h_b), .m_p_o(p_b), .m_last_o(last_b),
        .level_o(level_b), .overflow_o(ovf_b)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [0:0]  h;
        logic [0:0]  p;
        logic        last;
    } elem_t;

    // Expected elements still to be streamed, per instance.
    elem_t qa[$];
    elem_t qb[$];

    int checks = 0;
    int errors = 0;

    // Decision taken for the current cycle, applied to the model after the edge.
    bit          stg_acc  [2];
    bit          stg_drop [2];
    bit          stg_rst  [2];
    logic [63:0] stg_vec  [2];
    bit          ovf_exp  [2];
    bit          prev_hold[2];
    elem_t       prev_word[2];

    function automatic int nlanes(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int ptile(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string name, input int d,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d t=%0t got=%h exp=%h", name, d, $time, got, exp);
        end
    endtask

    // Apply last cycle's decision to the model (the DUT has just taken that edge).
    task automatic commit(input int d);
        logic [63:0] vec;
        elem_t       el;
        int          n;
        int          pt;
        n  = nlanes(d);
        pt = ptile(d);
        if (stg_rst[d]) begin
            if (d == 0) qa.delete(); else qb.delete();
            ovf_exp[d] = 1'b0;
        end else begin
            if (stg_acc[d]) begin
                vec = stg_vec[d];
                for (int hp = 0; hp < n; hp++) begin
                    el.data = vec[16*hp +: 16];
                    el.h    = 1'(hp / pt);
                    el.p    = 1'(hp % pt);
                    el.last = (hp == n - 1);
                    if (d == 0) qa.push_back(el); else qb.push_back(el);
                end
            end
            if (stg_drop[d]) ovf_exp[d] = 1'b1;
        end
        stg_acc[d]  = 1'b0;
        stg_drop[d] = 1'b0;
        stg_rst[d]  = 1'b0;
    endtask

    // One clock cycle of stimulus for instance d.
    task automatic step(input int d, input bit v, input logic [63:0] vec,
                        input bit rdy, input bit r);
        int e;
        int n;
        int vecs;
        bit pop;
        @(posedge clk);
        #1;
        commit(d);
        n    = nlanes(d);
        e    = qsize(d);
        vecs = (e + n - 1) / n;
        // The head vector completes this cycle if exactly one lane of it remains.
        pop  = rdy && (e > 0) && ((e % n) == (1 % n));
        if (r) begin
            stg_rst[d] = 1'b1;
        end else begin
            stg_acc[d]  = v && ((vecs < 4) || pop);
            stg_drop[d] = v && !stg_acc[d];
            stg_vec[d]  = vec;
        end
        if (d == 0) begin
            rst_a = r; valid_a = v && !r; y_a = vec; ready_a = rdy;
        end else begin
            rst_b = r; valid_b = v && !r; y_b = vec[15:0]; ready_b = rdy;
        end
    endtask

    // Per-cycle comparison of one instance against the model.
    task automatic mon(input int d);
        bit         v, rdy, r, ovf;
        logic [2:0] lvl;
        elem_t      w, ex;
        int         e, n;
        if (d == 0) begin
            v = mv_a; rdy = ready_a; r = rst_a; ovf = ovf_a; lvl = level_a;
            w = {data_a, h_a, p_a, last_a};
        end else begin
            v = mv_b; rdy = ready_b; r = rst_b; ovf = ovf_b; lvl = level_b;
            w = {data_b, h_b, p_b, last_b};
        end
        if (r) begin
            prev_hold[d] = 1'b0;
            return;
        end
        n = nlanes(d);
        e = qsize(d);
        check("valid", d, 32'(v), 32'(e > 0));
        check("level", d, 32'(lvl), 32'((e + n - 1) / n));
        check("overflow", d, 32'(ovf), 32'(ovf_exp[d]));
        if (prev_hold[d] && v) check("hold", d, 32'(w), 32'(prev_word[d]));
        if (!v) check("idle_outputs", d, 32'(w), 32'd0);
        if (v && rdy) begin
            if (e == 0) begin
                check("beat_unexpected", d, 32'd1, 32'd0);
            end else begin
                ex = (d == 0) ? qa.pop_front() : qb.pop_front();
                check("beat_data", d, 32'(w.data), 32'(ex.data));
                check("beat_h",    d, 32'(w.h),    32'(ex.h));
                check("beat_p",    d, 32'(w.p),    32'(ex.p));
                check("beat_last", d, 32'(w.last), 32'(ex.last));
            end
        end
        prev_hold[d] = v && !rdy;
        prev_word[d] = w;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        rst_a = 1'b1; valid_a = 1'b0; ready_a = 1'b0; y_a = '0;
        rst_b = 1'b1; valid_b = 1'b0; ready_b = 1'b0; y_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Single vector, ready always high.
        step(0, 1, 64'h4400_4200_4000_3C00, 1, 0);
        repeat (6) step(0, 0, '0, 1, 0);

        // Same vector, ready low for the three cycles after the first beat.
        step(0, 1, 64'h4400_4200_4000_3C00, 1, 0);
        step(0, 0, '0, 1, 0);
        repeat (3) step(0, 0, '0, 0, 0);
        repeat (6) step(0, 0, '0, 1, 0);

        // Five back-to-back vectors into a stalled FIFO: the fifth is dropped.
        for (int i = 1; i <= 5; i++) step(0, 1, {rand64() >> 16, 16'(i)}, 0, 0);
        repeat (2) step(0, 0, '0, 0, 0);
        repeat (20) step(0, 0, '0, 1, 0);

        // Clear the sticky flag.
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);

        // Full FIFO with a write landing on the head's last-lane beat.
        for (int i = 0; i < 4; i++) step(0, 1, rand64(), 0, 0);
        repeat (3) step(0, 0, '0, 1, 0);
        step(0, 1, rand64(), 1, 0);
        repeat (24) step(0, 0, '0, 1, 0);

        // Reset in the middle of a streamed vector with two more queued.
        for (int i = 0; i < 3; i++) step(0, 1, rand64(), 0, 0);
        repeat (2) step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 1);
        step(0, 1, rand64(), 1, 0);
        repeat (8) step(0, 0, '0, 1, 0);

        // Random traffic with occasional resets.
        repeat (400) step(0, $urandom_range(0, 4) == 0, rand64(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        repeat (30) step(0, 0, '0, 1, 0);

        // One-lane instance: one vector per cycle, then random traffic.
        repeat (6) step(1, 1, rand64(), 1, 0);
        repeat (3) step(1, 0, '0, 1, 0);
        repeat (200) step(1, $urandom_range(0, 1) == 0, rand64(),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        repeat (10) step(1, 0, '0, 1, 0);

        @(negedge clk);
        #1;
        check("drain_empty", 0, 32'(qsize(0)), 32'd0);
        check("drain_empty", 1, 32'(qsize(1)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
